// File: rtl/store_merge_unit.sv
// Store path into a word-wide data RAM: word stores write directly,
// byte/half stores read-modify-write the addressed word.
module store_merge_unit #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        ERR
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    state_t      state;
    state_t      nxt;
    logic [1:0]  a_q;
    logic [15:0] d_q;
    logic [1:0]  s_q;
    logic [31:0] merged;
    logic        illegal;
    logic        accept;
    logic        unused_hi;

    // Upper address bits simply wrap within the memory.
    assign unused_hi = ^req_addr[31:ADDR_W+2];

    always_comb begin
        illegal = 1'b0;
        unique case (req_size)
            SZ_B:    illegal = 1'b0;
            SZ_H:    illegal = req_addr[0];
            SZ_W:    illegal = (req_addr[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    assign accept = (state == IDLE) && req_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (illegal) begin
                        nxt = ERR;
                    end else if (req_size == SZ_W) begin
                        nxt = WRITE;
                    end else begin
                        nxt = READ;
                    end
                end
            end
            READ:    nxt = WAIT;
            WAIT:    nxt = WRITE;
            WRITE:   nxt = IDLE;
            ERR:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        mem_rd_en = (state == READ);
        mem_wr_en = (state == WRITE);
        done      = (state == WRITE);
        err       = (state == ERR);
    end

    // Lane replacement over the word returned by the RAM.
    always_comb begin
        merged = mem_rdata;
        if (s_q == SZ_H) begin
            if (a_q[1]) begin
                merged[31:16] = d_q;
            end else begin
                merged[15:0] = d_q;
            end
        end else begin
            unique case (a_q)
                2'd0:    merged[7:0]   = d_q[7:0];
                2'd1:    merged[15:8]  = d_q[7:0];
                2'd2:    merged[23:16] = d_q[7:0];
                default: merged[31:24] = d_q[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q       <= '0;
            d_q       <= '0;
            s_q       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (accept && !illegal) begin
            a_q      <= req_addr[1:0];
            d_q      <= req_wdata[15:0];
            s_q      <= req_size;
            mem_addr <= req_addr[ADDR_W+1:2];
            if (req_size == SZ_W) begin
                mem_wdata <= req_wdata;
            end
        end else if (state == WAIT) begin
            mem_wdata <= merged;
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit with a behavioural
// synchronous RAM model.
module tb_store_merge_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_wr_en;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;

    logic [31:0] ram [0:255];
    logic [31:0] rdata_q = '0;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;

    store_merge_unit #(.ADDR_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_size (req_size),
        .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata),
        .mem_wr_en(mem_wr_en),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    assign mem_rdata = rdata_q;

    always @(posedge clk) begin
        if (mem_rd_en) rdata_q <= ram[mem_addr];
        if (mem_wr_en) ram[mem_addr] <= mem_wdata;
        if (done) done_cnt <= done_cnt + 1;
        if (mem_rd_en) rd_cnt <= rd_cnt + 1;
        if (mem_wr_en) wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [1:0] s);
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_size  = s;
    endtask

    task automatic rmw(input string tag,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [1:0] s,
                       input logic [7:0] wa,
                       input logic [31:0] exp);
        drive(a, d, s);
        tick();
        req_valid = 1'b0;
        check({tag, "_c1_rd"}, 32'(mem_rd_en), 32'd1);
        check({tag, "_c1_wr"}, 32'(mem_wr_en), 32'd0);
        check({tag, "_c1_addr"}, 32'(mem_addr), 32'(wa));
        check({tag, "_c1_rdy"}, 32'(req_ready), 32'd0);
        tick();
        check({tag, "_c2_strb"}, {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        tick();
        check({tag, "_c3_wr"}, 32'(mem_wr_en), 32'd1);
        check({tag, "_c3_done"}, 32'(done), 32'd1);
        check({tag, "_c3_wdata"}, mem_wdata, exp);
        tick();
        check({tag, "_idle_rdy"}, 32'(req_ready), 32'd1);
        check({tag, "_ram"}, ram[wa], exp);
    endtask

    task automatic bad(input string tag,
                       input logic [31:0] a,
                       input logic [1:0] s);
        int r0;
        int w0;
        r0 = rd_cnt;
        w0 = wr_cnt;
        drive(a, 32'h5555_AAAA, s);
        tick();
        req_valid = 1'b0;
        check({tag, "_err"}, 32'(err), 32'd1);
        check({tag, "_strb"}, {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        tick();
        check({tag, "_rdy"}, 32'(req_ready), 32'd1);
        check({tag, "_err_off"}, 32'(err), 32'd0);
        check({tag, "_noacc"}, rd_cnt - r0 + wr_cnt - w0, 0);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 256; i++) ram[i] = '0;
        tick();
        check("rst_rdy", 32'(req_ready), 32'd1);
        check("rst_strb", {28'd0, mem_rd_en, mem_wr_en, done, err}, 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        tick();

        drive(32'h10, 32'hDEAD_BEEF, 2'b10);
        tick();
        req_valid = 1'b0;
        check("sw_wr", 32'(mem_wr_en), 32'd1);
        check("sw_done", 32'(done), 32'd1);
        check("sw_rd", 32'(mem_rd_en), 32'd0);
        check("sw_addr", 32'(mem_addr), 32'd4);
        check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        check("sw_idle", {30'd0, req_ready, done}, 32'd2);
        check("sw_ram", ram[4], 32'hDEAD_BEEF);

        ram[4] = 32'h1122_3344;
        rmw("sb12", 32'h12, 32'hFFFF_FFAB, 2'b00, 8'd4, 32'h11AB_3344);
        ram[4] = 32'h1122_3344;
        rmw("sh12", 32'h12, 32'h0000_BEEF, 2'b01, 8'd4, 32'hBEEF_3344);
        ram[4] = 32'h1122_3344;
        rmw("sh10", 32'h10, 32'h0000_BEEF, 2'b01, 8'd4, 32'h1122_BEEF);
        ram[9] = 32'hA0B0_C0D0;
        rmw("sb27", 32'h27, 32'h0000_0012, 2'b00, 8'd9, 32'h12B0_C0D0);
        ram[1] = 32'h0102_0304;
        rmw("wrap", 32'h8000_0405, 32'h0000_0077, 2'b00, 8'd1,
            32'h0102_7704);

        bad("sh13", 32'h13, 2'b01);
        bad("sw12", 32'h12, 2'b10);
        bad("sz11", 32'h10, 2'b11);

        ram[8] = 32'h0BAD_F00D;
        drive(32'h20, 32'h0000_0099, 2'b00);
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("rst_mid_strb", {28'd0, mem_rd_en, mem_wr_en, done, err},
              32'd0);
        check("rst_mid_addr", 32'(mem_addr), 32'd0);
        check("rst_mid_wdata", mem_wdata, 32'd0);
        check("rst_mid_rdy", 32'(req_ready), 32'd1);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_mid_ram", ram[8], 32'h0BAD_F00D);
        drive(32'h20, 32'h1234_5678, 2'b10);
        tick();
        req_valid = 1'b0;
        check("post_rst_wr", 32'(mem_wr_en), 32'd1);
        check("post_rst_wd", mem_wdata, 32'h1234_5678);
        tick();
        check("post_rst_ram", ram[8], 32'h1234_5678);

        ram[5] = 32'h0102_0304;
        ram[6] = 32'h0;
        d0 = done_cnt;
        drive(32'h14, 32'h0000_00AA, 2'b00);
        tick();
        drive(32'h18, 32'hCAFE_F00D, 2'b10);
        check("b2b_c1_rdy", 32'(req_ready), 32'd0);
        tick();
        check("b2b_c2_rdy", 32'(req_ready), 32'd0);
        tick();
        check("b2b_c3_rdy", 32'(req_ready), 32'd0);
        check("b2b_c3_wd", mem_wdata, 32'h0102_03AA);
        tick();
        check("b2b_c4_rdy", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("b2b_c5_wr", 32'(mem_wr_en), 32'd1);
        check("b2b_c5_addr", 32'(mem_addr), 32'd6);
        check("b2b_c5_wd", mem_wdata, 32'hCAFE_F00D);
        tick();
        tick();
        check("b2b_ram5", ram[5], 32'h0102_03AA);
        check("b2b_ram6", ram[6], 32'hCAFE_F00D);
        check("b2b_done", done_cnt - d0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
